c17_misr_analyzer: RTL
======================

Name: c17_misr_analyzer

Overview:
- Response-side BIST stage placed directly downstream of the c17 benchmark netlist.
- Compacts the 2-bit c17 output stream into a MISR signature over a programmed number of patterns.
- Compares the signature to a golden value and flags pass or fail; a fail means a trojan or fault is suspected.
- Sits between the c17 instance and the trojan-detection status logic.

Parameters:
- RESP_W, 2: width of the compacted response (c17 out bus).
- SIG_W, 16: MISR width; must be greater than or equal to RESP_W.
- POLY, 16'h1021: feedback taps XORed in when the shifted-out MSB is 1 (implicit x^SIG_W term).
- SEED, 16'h0000: MISR value loaded on start.
- CNT_W, 16: width of the pattern counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a session (honoured only in IDLE or DONE)
- abort  in  1  return to IDLE immediately; no verdict
- num_patterns  in  CNT_W  responses to compact; sampled on start
- golden_sig  in  SIG_W  expected signature; sampled on start
- resp_valid  in  1  resp_data is valid this cycle
- resp_data  in  RESP_W  c17 output {out[1],out[0]}
- resp_ready  out  1  high only in RUN
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE; held until the next start or abort
- pass  out  1  valid when done=1; 1 means signature == golden
- signature  out  SIG_W  current MISR contents
- count  out  CNT_W  responses accepted in the current session

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, signature=SEED.
  - count, resp_ready, busy, done and pass all 0.
  - Stored num_patterns and golden_sig cleared to 0.
- Fire: resp_valid & resp_ready. Only fires update the MISR or count.
- MISR update on fire:
  - sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_data).
  - count increments by 1 with no wrap; the session ends before overflow.
- FSM:
  - IDLE: on start, latch num_patterns and golden_sig, load signature=SEED and count=0. Go to CHECK if num_patterns==0, otherwise RUN.
  - RUN: resp_ready=1. A fire while count==num_patterns-1 performs that final update, then goes to CHECK. Non-valid cycles hold all state.
  - CHECK: exactly one cycle, resp_ready=0. Registers pass = (signature==golden_sig), then goes to DONE.
  - DONE: done=1; signature and pass frozen. start behaves as in IDLE and clears done and pass in the same edge.
- Latency: done rises 2 cycles after the final fire edge (CHECK cycle, then DONE).
- Simultaneous events:
  - abort has priority over start and over a fire in the same cycle: go to IDLE, clear done and pass, keep signature.
  - start in RUN or CHECK is ignored.
- rst_n asserted mid-session: immediate return to reset values; no partial verdict is retained.
- resp_data is ignored outside fires; X on resp_data while resp_valid=0 must not propagate.

Decomposition:
- Shared package bist_pkg:
  - FSM state enum: IDLE, RUN, CHECK, DONE.
  - Default POLY and SEED constants.
  - Function misr_step(sig, resp), reused by the matching upstream LFSR generator and the testbench model.
- One natural sub-module, misr_reg: parameterized SIG_W/RESP_W/POLY. Ports: clk, rst_n, load, seed, en, resp, sig.
- Top-level keeps the FSM, counter and compare.

Test Plan:
- Reset: rst_n low mid-RUN -> next cycle state IDLE, signature=16'h0000, busy=0, done=0.
- Basic: start with num_patterns=1, golden=16'h0001, one fire resp=2'b01 -> signature=16'h0001; done at fire+2 cycles with pass=1.
- Two patterns 2'b01 then 2'b10, golden=16'h0000 -> intermediate 16'h0001, final 16'h0000, pass=1. Same run with golden=16'h0003 -> pass=0.
- Feedback: SEED overridden to 16'h8000, num_patterns=1, resp=2'b00 -> signature=16'h1021.
- Zero patterns: start with num_patterns=0, golden=SEED -> no fire accepted, resp_ready never 1, done after 2 cycles, pass=1.
- Abort and backpressure: resp_valid toggling 1,0,1 with num_patterns=3 -> count advances only on valid cycles. abort together with resp_valid on the 2nd fire -> IDLE, count=1, done=0. A later start works normally.

Source files
------------

// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the c17 response-side BIST stage.
//   - bist_state_e : session FSM states (IDLE, RUN, CHECK, DONE)
//   - DEF_POLY / DEF_SEED : default MISR feedback taps and start value
//   - misr_step()  : one MISR update for the default 16-bit / 2-bit widths,
//                    shared with the matching upstream LFSR generator
// ---------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam int          DEF_SIG_W  = 16;
    localparam int          DEF_RESP_W = 2;
    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'h0000;

    // Shift left, fold the x^16 term back through the taps when the
    // outgoing MSB is set, then XOR the zero-extended response in.
    function automatic logic [DEF_SIG_W-1:0] misr_step(
        input logic [DEF_SIG_W-1:0]  sig,
        input logic [DEF_RESP_W-1:0] resp
    );
        logic [DEF_SIG_W-1:0] nxt;
        nxt = {sig[DEF_SIG_W-2:0], 1'b0};
        if (sig[DEF_SIG_W-1]) begin
            nxt = nxt ^ DEF_POLY;
        end
        nxt = nxt ^ {{(DEF_SIG_W-DEF_RESP_W){1'b0}}, resp};
        return nxt;
    endfunction

endpackage

// File: rtl/c17_misr_analyzer_if.sv
// ---------------------------------------------------------------------------
// c17_misr_analyzer_if
// Control, response stream and status bundle of the c17 MISR analyzer.
//   slave  modport : the analyzer (consumes start/abort/config/response,
//                    drives ready/status/signature/count)
//   master modport : the controller / response source driving the analyzer
// Signals:
//   start, abort             session control pulses
//   num_patterns, golden_sig session configuration, sampled on start
//   resp_valid, resp_data    c17 response stream, resp_ready back-pressure
//   busy, done, pass         session status and verdict
//   signature, count         live MISR contents and accepted-response count
// ---------------------------------------------------------------------------
interface c17_misr_analyzer_if #(
    parameter int RESP_W = 2,
    parameter int SIG_W  = 16,
    parameter int CNT_W  = 16
);

    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_patterns;
    logic [SIG_W-1:0]  golden_sig;
    logic              resp_valid;
    logic [RESP_W-1:0] resp_data;
    logic              resp_ready;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  start,
        input  abort,
        input  num_patterns,
        input  golden_sig,
        input  resp_valid,
        input  resp_data,
        output resp_ready,
        output busy,
        output done,
        output pass,
        output signature,
        output count
    );

    modport master (
        output start,
        output abort,
        output num_patterns,
        output golden_sig,
        output resp_valid,
        output resp_data,
        input  resp_ready,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  count
    );

endinterface

// File: rtl/misr_reg.sv
// ---------------------------------------------------------------------------
// misr_reg
// Multiple-input signature register with Galois-style feedback.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (to RESET_VAL)
//   load       : load seed (takes precedence over en)
//   seed       : value loaded when load is high
//   en         : compact resp into the signature this cycle
//   resp       : response word, zero-extended to SIG_W
//   sig        : current signature
// ---------------------------------------------------------------------------
module misr_reg #(
    parameter int               SIG_W     = 16,
    parameter int               RESP_W    = 2,
    parameter logic [SIG_W-1:0] POLY      = 16'h1021,
    parameter logic [SIG_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Next signature. resp is only looked at when en is high, so garbage on
    // the response bus during idle cycles never reaches the register.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c17_misr_analyzer.sv
// ---------------------------------------------------------------------------
// c17_misr_analyzer
// Compacts the c17 response stream into a MISR signature over a programmed
// number of patterns and compares it against a golden signature. A fail
// verdict means a trojan or fault is suspected in the c17 instance.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : c17_misr_analyzer_if.slave (control, response stream, status)
// Session: IDLE --start--> RUN (num_patterns fires) --> CHECK (1 cycle,
// registers verdict) --> DONE (verdict held until next start or abort).
// ---------------------------------------------------------------------------
module c17_misr_analyzer
    import bist_pkg::*;
#(
    parameter int               RESP_W = 2,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    c17_misr_analyzer_if.slave bus
);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] num_q,   num_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic             pass_q,  pass_d;

    logic             misr_load;
    logic             misr_en;
    logic             fire;
    logic [SIG_W-1:0] sig;

    // A response is only consumed while RUN advertises ready.
    assign fire = bus.resp_valid && (state_q == RUN);

    // Next-state logic. abort overrides everything, including a start or a
    // fire in the same cycle; the signature and count are left as they
    // were so the partial session can still be inspected.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        num_d     = num_q;
        golden_d  = golden_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        num_d     = bus.num_patterns;
                        golden_d  = bus.golden_sig;
                        count_d   = '0;
                        pass_d    = 1'b0;
                        misr_load = 1'b1;
                        state_d   = (bus.num_patterns == '0) ? CHECK : RUN;
                    end
                end
                RUN: begin
                    if (fire) begin
                        misr_en = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        if (count_q == num_q - CNT_W'(1)) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    pass_d  = (sig == golden_q);
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Session registers; reset discards any partial verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            num_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            num_q    <= num_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    misr_reg #(
        .SIG_W     (SIG_W),
        .RESP_W    (RESP_W),
        .POLY      (POLY),
        .RESET_VAL (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (misr_load),
        .seed  (SEED),
        .en    (misr_en),
        .resp  (bus.resp_data),
        .sig   (sig)
    );

    assign bus.resp_ready = (state_q == RUN);
    assign bus.busy       = (state_q == RUN) || (state_q == CHECK);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = pass_q;
    assign bus.signature  = sig;
    assign bus.count      = count_q;

endmodule
